// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache, 4 words per line.
// Zero-latency hits, 4-beat refill from a combinational instruction memory.
module icache_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [15:0]              miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - 4 - IDX_W;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [1:0]                 r_cnt;
    logic [SETS-1:0]            r_valid;
    logic [TAG_W-1:0]           r_tag  [SETS];
    logic [DATA_WIDTH-1:0]      r_data [SETS][4];
    logic [ADDRESS_WIDTH-1:0]   r_refill_addr;
    logic [15:0]                r_miss_count;

    logic [1:0]                 w_word;
    logic [IDX_W-1:0]           w_idx;
    logic [TAG_W-1:0]           w_tag;
    logic [IDX_W-1:0]           w_ridx;
    logic [TAG_W-1:0]           w_rtag;
    logic                       w_lookup;
    logic                       w_miss;
    logic [ADDRESS_WIDTH-1:0]   w_beat_off;
    logic                       w_unused;

    assign w_word     = cpu_addr[3:2];
    assign w_idx      = cpu_addr[4 +: IDX_W];
    assign w_tag      = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign w_ridx     = r_refill_addr[4 +: IDX_W];
    assign w_rtag     = r_refill_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign w_lookup   = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss     = (r_state == S_IDLE) & cpu_req & ~flush & ~w_lookup;
    assign w_beat_off = {{(ADDRESS_WIDTH-4){1'b0}}, r_cnt, 2'b00};
    assign w_unused   = ^cpu_addr[1:0];
    assign miss_count = r_miss_count;

    // State register: reset overrides everything, else follow next-state logic.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state: a miss starts a refill; flush or the last beat ends it.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_miss) w_next = S_REFILL;
            S_REFILL: if (flush || r_cnt == 2'd3) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs: read path is always the indexed word; stall on miss/flush/refill.
    always_comb begin
        cpu_rdata = r_data[w_idx][w_word];
        cpu_stall = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        unique case (r_state)
            S_IDLE: begin
                cpu_stall = flush | (cpu_req & ~w_lookup);
            end
            S_REFILL: begin
                cpu_stall = 1'b1;
                if (!rst) begin
                    mem_req  = 1'b1;
                    mem_addr = r_refill_addr + w_beat_off;
                end
            end
            default: cpu_stall = 1'b1;
        endcase
    end

    // Control state: valid bits, beat counter, refill base, miss counter.
    // The victim line is invalidated at the miss edge so it never hits half-written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= 2'd0;
            r_valid       <= '0;
            r_refill_addr <= '0;
            r_miss_count  <= 16'd0;
        end else if (flush) begin
            r_valid <= '0;
            r_cnt   <= 2'd0;
        end else if (r_state == S_IDLE) begin
            if (w_miss) begin
                r_refill_addr   <= {cpu_addr[ADDRESS_WIDTH-1:4], 4'b0000};
                r_cnt           <= 2'd0;
                r_valid[w_idx]  <= 1'b0;
                if (r_miss_count != 16'hFFFF)
                    r_miss_count <= r_miss_count + 16'd1;
            end
        end else begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3)
                r_valid[w_ridx] <= 1'b1;
        end
    end

    // Storage arrays (unreset): capture refill beats, tag written with the last beat.
    always_ff @(posedge clk) begin
        if (!rst && !flush && r_state == S_REFILL) begin
            r_data[w_ridx][r_cnt] <= mem_rdata;
            if (r_cnt == 2'd3)
                r_tag[w_ridx] <= w_rtag;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scoreboard bench for icache_ctrl.
// Expected fetch words and refill addresses are queued by stimulus, popped by a monitor.
module tb_icache_ctrl;

    localparam logic [31:0] K = 32'h5A5A_1234;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        flush;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [15:0] miss_count;

    int tot;
    int errs;
    logic [31:0] q_data[$];
    logic [31:0] q_mem[$];
    logic [15:0] em;

    icache_ctrl #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .SETS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .flush(flush),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .miss_count(miss_count)
    );

    // Instruction memory: each word is its own address xor a constant.
    assign mem_rdata = mem_addr ^ K;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ K;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT serves a fetch or a refill beat.
    always @(negedge clk) begin
        if (cpu_req && !cpu_stall && !rst) begin
            if (q_data.size() == 0) chk("unexpected_fetch", cpu_rdata, 32'hX);
            else chk("fetch_data", cpu_rdata, q_data.pop_front());
        end
        if (mem_req) begin
            if (q_mem.size() == 0) chk("unexpected_mem_req", mem_addr, 32'hX);
            else chk("mem_addr", mem_addr, q_mem.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_served(output int s);
        bit done;
        s = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1;
            else s++;
        end
        if (!done) chk("serve_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            q_mem.push_back({a[31:4], 4'b0000} + 32'(i * 4));
    endtask

    task automatic fetch(input logic [31:0] a, input bit miss);
        int s;
        cpu_req  = 1'b1;
        cpu_addr = a;
        q_data.push_back(exp_word(a));
        if (miss) begin
            push_line(a);
            em = (em == 16'hFFFF) ? em : em + 16'd1;
        end
        wait_served(s);
        chk(miss ? "miss_stall_cycles" : "hit_stall_cycles", s, miss ? 5 : 0);
        cpu_req = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        cpu_req = 1'b0;
        flush   = 1'b0;
        step();
        step();
        rst = 1'b0;
        em  = 16'd0;
        @(negedge clk);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_miss_count", miss_count, 0);
        step();
    endtask

    // Start a miss then abort it with flush on the first refill beat.
    task automatic quick_miss(input logic [31:0] a);
        cpu_req  = 1'b1;
        cpu_addr = a;
        q_mem.push_back({a[31:4], 4'b0000});
        em = (em == 16'hFFFF) ? em : em + 16'd1;
        step();
        flush   = 1'b1;
        cpu_req = 1'b0;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int s;
        tot      = 0;
        errs     = 0;
        em       = 0;
        rst      = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        flush    = 1'b0;

        // Cold fetch and sequential hits
        do_reset();
        fetch(32'hBFC0_0000, 1);
        chk("cold_miss_count", miss_count, em);
        fetch(32'hBFC0_0004, 0);
        fetch(32'hBFC0_0008, 0);
        fetch(32'hBFC0_000C, 0);
        chk("hits_miss_count", miss_count, em);

        // Conflict on index 0
        do_reset();
        fetch(32'hBFC0_0000, 1);
        fetch(32'hBFC0_0080, 1);
        fetch(32'hBFC0_0000, 1);
        chk("conflict_miss_count", miss_count, 16'd3);

        // Address change during refill of line 1
        cpu_req  = 1'b1;
        cpu_addr = 32'hBFC0_0010;
        push_line(32'hBFC0_0010);
        push_line(32'hBFC0_0200);
        q_data.push_back(exp_word(32'hBFC0_0200));
        em = em + 16'd2;
        @(negedge clk);
        chk("chg_miss_stall", cpu_stall, 1);
        step();
        step();
        cpu_addr = 32'hBFC0_0200;
        wait_served(s);
        chk("chg_stall_cycles", s, 8);
        cpu_req = 1'b0;
        fetch(32'hBFC0_0010, 0);
        chk("chg_miss_count", miss_count, em);

        // Flush in IDLE after hits
        fetch(32'hBFC0_0014, 0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", cpu_stall, 1);
        chk("flush_idle_mem_req", mem_req, 0);
        step();
        flush = 1'b0;
        fetch(32'hBFC0_0200, 1);

        // Flush on refill beat cnt=1
        cpu_req  = 1'b1;
        cpu_addr = 32'hBFC0_0010;
        q_mem.push_back(32'hBFC0_0010);
        q_mem.push_back(32'hBFC0_0014);
        em = em + 16'd1;
        @(negedge clk);
        chk("abort_miss_stall", cpu_stall, 1);
        step();
        step();
        flush   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", mem_req, 1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("abort_idle_mem_req", mem_req, 0);
        chk("abort_idle_stall", cpu_stall, 0);
        step();
        fetch(32'hBFC0_0010, 1);
        chk("flush_miss_count", miss_count, em);

        // Reset on refill beat cnt=2
        cpu_req  = 1'b1;
        cpu_addr = 32'hBFC0_0040;
        q_mem.push_back(32'hBFC0_0040);
        q_mem.push_back(32'hBFC0_0044);
        step();
        step();
        step();
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_req", mem_req, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        step();
        rst = 1'b0;
        em  = 16'd0;
        @(negedge clk);
        chk("rst_mid_idle_mem_req", mem_req, 0);
        chk("rst_mid_miss_count", miss_count, 0);
        step();
        fetch(32'hBFC0_0010, 1);
        fetch(32'hBFC0_0040, 1);
        chk("rst_mid_after_count", miss_count, 16'd2);

        // Saturation: preload the counter near the top, then keep missing
        force dut.r_miss_count = 16'hFFFD;
        #1;
        release dut.r_miss_count;
        em = 16'hFFFD;
        step();
        for (int i = 0; i < 4; i++) begin
            quick_miss(32'hBFC0_1000 + 32'(i * 16));
            chk("sat_miss_count", miss_count, em);
        end
        chk("sat_final", miss_count, 16'hFFFF);

        step();
        chk("q_data_empty", q_data.size(), 0);
        chk("q_mem_empty", q_mem.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", tot, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
